// File: rtl/vdc_pwm.sv
// vdc_pwm: variable-duty-cycle PWM output stage for the heater switch.
//
// Turns the PID high-time word NH into a fixed-period PWM drive. The
// requested high time is clamped, then latched only at period boundaries,
// so the output never glitches mid-period. Dropping 'on' truncates the
// pulse on the next edge, which is the heater's safety behaviour.
//
// Ports:
//   clk          in   clock, the only clock
//   rst          in   synchronous active-high reset
//   on           in   output enable; low forces idle on the next edge
//   NH           in   signed requested high time in clk cycles
//   vdc_out      out  registered PWM drive
//   period_start out  registered one-cycle strobe on the first cycle of a period
//   NH_active    out  clamped high time in effect for the current period
//   clip         out  high for the whole period when NH_active differs from NH
module vdc_pwm #(
    parameter int FILTER_IO_SIZE = 18,
    parameter int PERIOD         = 100000,
    parameter int MIN_ON         = 50,
    parameter int MIN_OFF        = 50,
    parameter int CW             = $clog2(PERIOD + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             on,
    input  logic signed [FILTER_IO_SIZE-1:0] NH,
    output logic                             vdc_out,
    output logic                             period_start,
    output logic [CW-1:0]                    NH_active,
    output logic                             clip
);

    // Wide signed working width so the clamp comparisons never overflow,
    // whatever FILTER_IO_SIZE and PERIOD are.
    localparam int WW = 64;
    localparam logic signed [WW-1:0] MIN_ON_W = WW'(MIN_ON);
    localparam logic signed [WW-1:0] FULL_W   = WW'(PERIOD - MIN_OFF);
    localparam logic signed [WW-1:0] PERIOD_W = WW'(PERIOD);
    localparam logic [CW-1:0]        LAST_CNT = CW'(PERIOD - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [CW-1:0]   shadow_reg, shadow_next;
    logic [CW-1:0]   nh_active_reg, nh_active_next;
    logic            clip_reg, clip_next;
    logic            vdc_reg, vdc_next;
    logic            ps_reg, ps_next;

    logic signed [WW-1:0] nh_wide;
    logic signed [WW-1:0] clamp_wide;
    logic [CW-1:0]        clamp_val;
    logic                 clamp_clip;
    logic [CW:0]          cnt_plus1;
    logic                 load;

    // Clamp: anything below MIN_ON (including zero and negatives) is
    // suppressed, anything too close to full-on becomes always-on.
    always_comb begin
        nh_wide = {{(WW - FILTER_IO_SIZE){NH[FILTER_IO_SIZE-1]}}, NH};
        if (nh_wide < MIN_ON_W) begin
            clamp_wide = '0;
        end else if (nh_wide >= FULL_W) begin
            clamp_wide = PERIOD_W;
        end else begin
            clamp_wide = nh_wide;
        end
        clamp_val  = clamp_wide[CW-1:0];
        clamp_clip = (clamp_wide != nh_wide);
    end

    // One extra bit so cnt+1 < shadow is exact even when shadow == PERIOD.
    assign cnt_plus1 = {1'b0, cnt_reg} + (CW + 1)'(1);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shadow_next    = shadow_reg;
        nh_active_next = nh_active_reg;
        clip_next      = clip_reg;
        vdc_next       = vdc_reg;
        ps_next        = 1'b0;
        load           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (on) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (!on) begin
                    state_next = IDLE;
                end else if (cnt_reg == LAST_CNT) begin
                    load = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next == IDLE) begin
            cnt_next       = '0;
            shadow_next    = '0;
            nh_active_next = '0;
            clip_next      = 1'b0;
            vdc_next       = 1'b0;
        end else if (load) begin
            cnt_next       = '0;
            shadow_next    = clamp_val;
            nh_active_next = clamp_val;
            clip_next      = clamp_clip;
            ps_next        = 1'b1;
            vdc_next       = (clamp_val != '0);
        end else begin
            cnt_next = cnt_plus1[CW-1:0];
            vdc_next = (cnt_plus1 < {1'b0, shadow_reg});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shadow_reg    <= '0;
            nh_active_reg <= '0;
            clip_reg      <= 1'b0;
            vdc_reg       <= 1'b0;
            ps_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shadow_reg    <= shadow_next;
            nh_active_reg <= nh_active_next;
            clip_reg      <= clip_next;
            vdc_reg       <= vdc_next;
            ps_reg        <= ps_next;
        end
    end

    assign vdc_out      = vdc_reg;
    assign period_start = ps_reg;
    assign NH_active    = nh_active_reg;
    assign clip         = clip_reg;

endmodule

// File: tb/tb_vdc_pwm.sv
// Testbench for vdc_pwm with a short period (100 cycles, MIN_ON = MIN_OFF = 5).
// Directed scenario tasks check pulse shape against constants; a randomized
// phase checks every cycle against a period-level behavioural model.
module tb_vdc_pwm;

    localparam int FILTER_IO_SIZE = 18;
    localparam int PERIOD         = 100;
    localparam int MIN_ON         = 5;
    localparam int MIN_OFF        = 5;
    localparam int CW             = $clog2(PERIOD + 1);

    logic                             clk;
    logic                             rst;
    logic                             on;
    logic signed [FILTER_IO_SIZE-1:0] nh;
    logic                             vdc_out;
    logic                             period_start;
    logic [CW-1:0]                    NH_active;
    logic                             clip;

    int n_pass  = 0;
    int n_total = 0;

    vdc_pwm #(
        .FILTER_IO_SIZE(FILTER_IO_SIZE),
        .PERIOD        (PERIOD),
        .MIN_ON        (MIN_ON),
        .MIN_OFF       (MIN_OFF),
        .CW            (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .on          (on),
        .NH          (nh),
        .vdc_out     (vdc_out),
        .period_start(period_start),
        .NH_active   (NH_active),
        .clip        (clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int clampf(input int v);
        if (v <= 0)                     return 0;
        else if (v < MIN_ON)            return 0;
        else if (v >= PERIOD - MIN_OFF) return PERIOD;
        else                            return v;
    endfunction

    // Period-level view: whether a period is running, how far into it we are,
    // and the high time / clip flag latched when it began.
    int m_run  = 0;
    int m_off  = 0;
    int m_act  = 0;
    bit m_clip = 1'b0;

    always @(posedge clk) begin
        if (rst || !on) begin
            m_run = 0; m_off = 0; m_act = 0; m_clip = 1'b0;
        end else if (m_run == 0 || m_off == PERIOD - 1) begin
            m_run  = 1;
            m_off  = 0;
            m_act  = clampf(int'(nh));
            m_clip = (m_act != int'(nh));
        end else begin
            m_off++;
        end
    end

    function automatic logic [CW+2:0] model_vec();
        logic hi, ps;
        hi = (m_run != 0) && (m_off < m_act);
        ps = (m_run != 0) && (m_off == 0);
        return {hi, ps, CW'(m_act), m_clip};
    endfunction

    // ---------------- utilities ----------------
    task automatic wait_ps();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 2 * PERIOD);
        n_total++;
        if (period_start !== 1'b1)
            $display("FAIL wait_ps: period_start=%b after %0d cycles, required 1", period_start, n);
        else
            n_pass++;
    endtask

    // Observes one full period starting at a period_start negedge; ends on the
    // negedge of the following period's first cycle.
    task automatic measure_period(output int hi, output int pre, output int nps);
        bit broken;
        hi = 0; pre = 0; nps = 0; broken = 1'b0;
        for (int i = 0; i < PERIOD; i++) begin
            if (vdc_out === 1'b1) begin
                hi++;
                if (!broken) pre++;
            end else begin
                broken = 1'b1;
            end
            if (period_start === 1'b1) nps++;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; on = 1'b1; nh = 18'(25);
        repeat (3) @(negedge clk);
        n_total++;
        if ({vdc_out, period_start, NH_active, clip} !== '0)
            $display("FAIL reset_outputs: got %b, required 0", {vdc_out, period_start, NH_active, clip});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (period_start !== 1'b1)
            $display("FAIL reset_release_ps: period_start=%b, required 1", period_start);
        else n_pass++;
        $display("reset: released, period_start=%b", period_start);
    endtask

    task automatic test_duty();
        int hi, pre, nps;
        nh = 18'(25);
        wait_ps();
        for (int p = 0; p < 3; p++) begin
            n_total++;
            if (NH_active !== CW'(25) || clip !== 1'b0)
                $display("FAIL duty_latch: NH_active=%0d clip=%b, required 25/0", NH_active, clip);
            else n_pass++;
            measure_period(hi, pre, nps);
            n_total++;
            if (hi != 25 || pre != 25 || nps != 1 || period_start !== 1'b1)
                $display("FAIL duty_shape: high=%0d prefix=%0d strobes=%0d next_ps=%b, required 25/25/1/1",
                         hi, pre, nps, period_start);
            else n_pass++;
            $display("duty: period %0d high=%0d", p, hi);
        end
    endtask

    task automatic test_clamp();
        int tab_nh[9]   = '{3, -7, 97, 4, 5, 94, 95, 130, 50};
        int tab_act[9]  = '{0, 0, 100, 0, 5, 94, 100, 100, 50};
        bit tab_clip[9] = '{1, 1, 1, 1, 0, 0, 1, 1, 0};
        int hi, pre, nps;
        for (int k = 0; k < 9; k++) begin
            nh = 18'(tab_nh[k]);
            measure_period(hi, pre, nps);   // period latched before the change
            for (int p = 0; p < 3; p++) begin
                n_total++;
                if (NH_active !== CW'(tab_act[k]) || clip !== tab_clip[k])
                    $display("FAIL clamp_latch NH=%0d: NH_active=%0d clip=%b, required %0d/%b",
                             tab_nh[k], NH_active, clip, tab_act[k], tab_clip[k]);
                else n_pass++;
                measure_period(hi, pre, nps);
                n_total++;
                if (hi != tab_act[k] || pre != tab_act[k] || nps != 1)
                    $display("FAIL clamp_shape NH=%0d: high=%0d prefix=%0d strobes=%0d, required %0d/%0d/1",
                             tab_nh[k], hi, pre, nps, tab_act[k], tab_act[k]);
                else n_pass++;
            end
            $display("clamp: NH=%0d NH_active=%0d high=%0d", tab_nh[k], NH_active, hi);
        end
    endtask

    task automatic test_midchange();
        int hi, pre, nps;
        nh = 18'(25);
        measure_period(hi, pre, nps);
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i == 10) nh = 18'(60);
            if (vdc_out === 1'b1) hi++;
            @(negedge clk);
        end
        n_total++;
        if (hi != 25)
            $display("FAIL midchange_old: high=%0d, required 25", hi);
        else n_pass++;
        measure_period(hi, pre, nps);
        n_total++;
        if (hi != 60 || pre != 60)
            $display("FAIL midchange_new: high=%0d prefix=%0d, required 60/60", hi, pre);
        else n_pass++;
        $display("midchange: new period high=%0d", hi);
    endtask

    task automatic test_on_drop();
        int hi, pre, nps;
        nh = 18'(40);
        measure_period(hi, pre, nps);
        repeat (12) @(negedge clk);
        n_total++;
        if (vdc_out !== 1'b1)
            $display("FAIL ondrop_before: vdc_out=%b, required 1", vdc_out);
        else n_pass++;
        on = 1'b0;
        @(negedge clk);
        n_total++;
        if ({vdc_out, period_start, NH_active, clip} !== '0)
            $display("FAIL ondrop_idle: got %b, required 0", {vdc_out, period_start, NH_active, clip});
        else n_pass++;
        repeat (4) @(negedge clk);
        on = 1'b1;
        @(negedge clk);
        n_total++;
        if (period_start !== 1'b1 || NH_active !== CW'(40))
            $display("FAIL ondrop_restart: period_start=%b NH_active=%0d, required 1/40", period_start, NH_active);
        else n_pass++;
        measure_period(hi, pre, nps);
        n_total++;
        if (hi != 40 || pre != 40 || nps != 1)
            $display("FAIL ondrop_pulse: high=%0d prefix=%0d strobes=%0d, required 40/40/1", hi, pre, nps);
        else n_pass++;
        $display("ondrop: restarted pulse high=%0d", hi);
    endtask

    task automatic test_rst_mid();
        int hi, pre, nps;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({vdc_out, period_start, NH_active, clip} !== '0)
            $display("FAIL rstmid_outputs: got %b, required 0", {vdc_out, period_start, NH_active, clip});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (period_start !== 1'b1 || NH_active !== CW'(40))
            $display("FAIL rstmid_restart: period_start=%b NH_active=%0d, required 1/40", period_start, NH_active);
        else n_pass++;
        measure_period(hi, pre, nps);
        n_total++;
        if (hi != 40 || pre != 40)
            $display("FAIL rstmid_pulse: high=%0d prefix=%0d, required 40/40", hi, pre);
        else n_pass++;
        $display("rstmid: restarted pulse high=%0d", hi);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            n_total++;
            if ({vdc_out, period_start, NH_active, clip} !== model_vec()) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random cycle %0d: got %b, required %b", i,
                             {vdc_out, period_start, NH_active, clip}, model_vec());
            end else n_pass++;
            rst = ($urandom_range(699) == 0);
            if ($urandom_range(39) == 0) nh = 18'(int'($urandom_range(150)) - 20);
            if (on) on = ($urandom_range(299) != 0);
            else    on = ($urandom_range(7) == 0);
        end
        rst = 1'b0;
        $display("random: 4000 cycles, %0d mismatching", errs);
    endtask

    initial begin
        rst = 1'b1; on = 1'b0; nh = '0;
        test_reset();
        test_duty();
        test_clamp();
        test_midchange();
        test_on_drop();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
